// File: rtl/mult_chain_pkg.sv
// mult_chain_pkg: width helpers shared by the multiplier chain and its stages.
package mult_chain_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   function automatic int sum_w(input int w, input int s);
      return 2 * w + clog2(s);
   endfunction

endpackage

// File: rtl/mult_chain_stage.sv
// mult_chain_stage: one WIDTHxWIDTH soft multiplier stage with chained A operand.
// Exposes the aligned product sign flag only when MULT_CHAIN_SUM_EN is defined.
module mult_chain_stage
   import mult_chain_pkg::*;
#(
   parameter int   WIDTH   = 9,
   parameter int   OUT_REG = 1,
   parameter logic SOA_REG = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce,
   input  logic [WIDTH-1:0]           chain_a,
   input  logic                       chain_v,
   input  logic [WIDTH-1:0]           a_local,
   input  logic                       a_sel,
   input  logic [WIDTH-1:0]           b,
   input  logic                       valid_in,
   input  logic                       a_signed,
   input  logic                       b_signed,
   output logic [WIDTH-1:0]           so_a,
   output logic                       so_v,
`ifdef MULT_CHAIN_SUM_EN
   output logic                       sgn,
`endif
   output logic [prod_w(WIDTH)-1:0]   dout,
   output logic                       valid_out
);
   localparam int PW = prod_w(WIDTH);
   logic [WIDTH-1:0] a_r, b_r;
   logic av, bv, as_r, bs_r;
   logic [PW-1:0] ae, be, p;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_r  <= '0;
         av   <= 1'b0;
         b_r  <= '0;
         bv   <= 1'b0;
         as_r <= 1'b0;
         bs_r <= 1'b0;
      end else if (ce) begin
         a_r  <= a_sel ? chain_a : a_local;
         av   <= a_sel ? chain_v : valid_in;
         b_r  <= b;
         bv   <= valid_in;
         as_r <= a_signed;
         bs_r <= b_signed;
      end
   assign ae = {{WIDTH{as_r & a_r[WIDTH-1]}}, a_r};
   assign be = {{WIDTH{bs_r & b_r[WIDTH-1]}}, b_r};
   assign p  = ae * be;
   if (SOA_REG) begin : g_soa
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            so_a <= '0;
            so_v <= 1'b0;
         end else if (ce) begin
            so_a <= a_r;
            so_v <= av;
         end
   end else begin : g_nsoa
      assign so_a = a_r;
      assign so_v = av;
   end
   if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            dout      <= '0;
            valid_out <= 1'b0;
         end else if (ce) begin
            dout      <= p;
            valid_out <= av & bv;
         end
`ifdef MULT_CHAIN_SUM_EN
      // sign flag travels with the product it describes
      always_ff @(posedge clk or posedge reset)
         if (reset) sgn <= 1'b0;
         else if (ce) sgn <= as_r | bs_r;
`endif
   end else begin : g_comb
      assign dout      = p;
      assign valid_out = av & bv;
`ifdef MULT_CHAIN_SUM_EN
      assign sgn = as_r | bs_r;
`endif
   end
endmodule

// File: rtl/mult_chain.sv
// mult_chain: cascade of STAGES soft multipliers sharing a shifted A operand chain.
// Defining MULT_CHAIN_SUM_EN adds a registered sum of all products (sum_out, sum_valid).
module mult_chain
   import mult_chain_pkg::*;
#(
   parameter int                WIDTH   = 9,
   parameter int                STAGES  = 5,
   parameter int                OUT_REG = 1,
   parameter logic [STAGES-1:0] SOA_REG = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ce,
   input  logic                              valid_in,
   input  logic [WIDTH-1:0]                  si_a,
   input  logic [STAGES*WIDTH-1:0]           a_local,
   input  logic [STAGES-1:0]                 a_sel,
   input  logic [STAGES*WIDTH-1:0]           b,
   input  logic                              a_signed,
   input  logic                              b_signed,
   output logic [WIDTH-1:0]                  so_a,
   output logic [STAGES*prod_w(WIDTH)-1:0]   dout,
`ifdef MULT_CHAIN_SUM_EN
   output logic [sum_w(WIDTH, STAGES)-1:0]   sum_out,
   output logic                              sum_valid,
`endif
   output logic [STAGES-1:0]                 valid_out
);
   localparam int PW = prod_w(WIDTH);
   logic [WIDTH-1:0] ca [STAGES+1];
   logic [STAGES:0] cv;
   logic unused_v;
`ifdef MULT_CHAIN_SUM_EN
   logic [STAGES-1:0] sg;
`endif
   assign ca[0] = si_a;
   assign cv[0] = valid_in;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      mult_chain_stage #(
         .WIDTH(WIDTH),
         .OUT_REG(OUT_REG),
         .SOA_REG(SOA_REG[k])
      ) u_stage (
         .clk(clk),
         .reset(reset),
         .ce(ce),
         .chain_a(ca[k]),
         .chain_v(cv[k]),
         .a_local(a_local[k*WIDTH +: WIDTH]),
         .a_sel(a_sel[k]),
         .b(b[k*WIDTH +: WIDTH]),
         .valid_in(valid_in),
         .a_signed(a_signed),
         .b_signed(b_signed),
         .so_a(ca[k+1]),
         .so_v(cv[k+1]),
`ifdef MULT_CHAIN_SUM_EN
         .sgn(sg[k]),
`endif
         .dout(dout[k*PW +: PW]),
         .valid_out(valid_out[k])
      );
   end
   assign so_a = ca[STAGES];
   assign unused_v = cv[STAGES];
`ifdef MULT_CHAIN_SUM_EN
   localparam int SW = sum_w(WIDTH, STAGES);
   logic [SW-1:0] acc;
   always_comb begin
      acc = '0;
      for (int i = 0; i < STAGES; i++)
         acc = acc + (sg[i] ? SW'($signed(dout[i*PW +: PW])) : SW'(dout[i*PW +: PW]));
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sum_out   <= '0;
         sum_valid <= 1'b0;
      end else if (ce) begin
         sum_out   <= acc;
         sum_valid <= &valid_out;
      end
`endif
endmodule

// File: tb/tb_mult_chain.sv
// tb_mult_chain: directed vectors against a path-walking model of the multiplier chain.
// Sum checks are built only when MULT_CHAIN_SUM_EN is defined.
module tb_mult_chain;
   localparam int W = 9;
   localparam int S = 5;
   localparam int PW = 18;
   localparam int N = 512;
   localparam logic [S-1:0] SOA = 5'b01010;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ce = 1'b1;
   logic valid_in = 1'b0;
   logic a_signed = 1'b0;
   logic b_signed = 1'b0;
   logic [W-1:0] si_a = '0;
   logic [S*W-1:0] a_local = '0;
   logic [S*W-1:0] b = '0;
   logic [S-1:0] a_sel = '0;
   logic [W-1:0] so_a;
   logic [S*PW-1:0] dout;
   logic [S-1:0] valid_out;
`ifdef MULT_CHAIN_SUM_EN
   logic [PW+2:0] sum_out;
   logic sum_valid;
`endif

   int n_vec = 0;
   int n_bad = 0;

   mult_chain #(.WIDTH(W), .STAGES(S), .OUT_REG(1), .SOA_REG(SOA)) dut (
      .clk(clk),
      .reset(reset),
      .ce(ce),
      .valid_in(valid_in),
      .si_a(si_a),
      .a_local(a_local),
      .a_sel(a_sel),
      .b(b),
      .a_signed(a_signed),
      .b_signed(b_signed),
      .so_a(so_a),
      .dout(dout),
`ifdef MULT_CHAIN_SUM_EN
      .sum_out(sum_out),
      .sum_valid(sum_valid),
`endif
      .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   // input history indexed by enabled edges since the last reset
   logic [W-1:0] h_si [N];
   logic [S*W-1:0] h_al [N];
   logic [S*W-1:0] h_b [N];
   logic [S-1:0] h_asel [N];
   logic h_v [N];
   logic h_as [N];
   logic h_bs [N];
   int t = 0;

   always @(posedge clk or posedge reset)
      if (reset) t <= 0;
      else if (ce) begin
         h_si[t]   <= si_a;
         h_al[t]   <= a_local;
         h_b[t]    <= b;
         h_asel[t] <= a_sel;
         h_v[t]    <= valid_in;
         h_as[t]   <= a_signed;
         h_bs[t]   <= b_signed;
         t         <= t + 1;
      end

   // {valid, A} held by stage k after tt enabled edges: walk back along the chain path
   function automatic logic [W:0] a_at(int k, int tt);
      for (int j = k; j >= 0; j--) begin
         if (tt < 1) return '0;
         if (!h_asel[tt-1][j]) return {h_v[tt-1], h_al[tt-1][j*W +: W]};
         if (j == 0) return {h_v[tt-1], h_si[tt-1]};
         tt = tt - 1 - int'(SOA[j-1]);
      end
      return '0;
   endfunction

   // {valid, product} formed from the operand registers after tt enabled edges
   function automatic logic [PW:0] prod(int k, int tt);
      logic [W:0] av;
      logic [W-1:0] bb;
      int x, y;
      if (tt < 1) return '0;
      av = a_at(k, tt);
      bb = h_b[tt-1][k*W +: W];
      x = (h_as[tt-1] && av[W-1]) ? int'(av[W-1:0]) - (1 << W) : int'(av[W-1:0]);
      y = (h_bs[tt-1] && bb[W-1]) ? int'(bb) - (1 << W) : int'(bb);
      return {av[W] & h_v[tt-1], PW'(x * y)};
   endfunction

`ifdef MULT_CHAIN_SUM_EN
   function automatic logic [PW+3:0] sum_at(int tt);
      logic [PW+2:0] acc;
      logic v;
      logic f;
      logic [PW:0] p;
      acc = '0;
      v = 1'b1;
      f = (tt >= 3) && (h_as[tt-3] || h_bs[tt-3]);
      for (int k = 0; k < S; k++) begin
         p = prod(k, tt - 2);
         v = v & p[PW];
         acc = acc + (f ? {{3{p[PW-1]}}, p[PW-1:0]} : {3'b000, p[PW-1:0]});
      end
      return {v, acc};
   endfunction
`endif

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   logic [PW:0] e;
   logic [W:0] es;
`ifdef MULT_CHAIN_SUM_EN
   logic [PW+3:0] esum;
`endif

   always @(negedge clk) begin
      for (int k = 0; k < S; k++) begin
         e = prod(k, t - 1);
         chk("model_dout", dout[k*PW +: PW], e[PW-1:0]);
         chk("model_valid", valid_out[k], e[PW]);
      end
      es = a_at(S - 1, t - int'(SOA[S-1]));
      chk("model_so_a", so_a, es[W-1:0]);
`ifdef MULT_CHAIN_SUM_EN
      esum = sum_at(t);
      chk("model_sum", sum_out, esum[PW+2:0]);
      chk("model_sum_valid", sum_valid, esum[PW+3]);
`endif
   end

   task automatic flush(input int n);
      valid_in = 1'b0;
      si_a = '0;
      a_local = '0;
      b = '0;
      a_signed = 1'b0;
      b_signed = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_dout", dout, 0);
      chk("reset_valid", valid_out, 0);
      chk("reset_so_a", so_a, 0);
      reset = 1'b0;
      // local multiply on stage 0
      @(negedge clk);
      a_local[W-1:0] = 9'h123;
      b[W-1:0] = 9'h0fd;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      a_local = '0;
      b = '0;
      chk("local_valid_early", valid_out[0], 0);
      @(negedge clk);
      chk("local_dout", dout[PW-1:0], 18'h11F97);
      chk("local_valid", valid_out[0], 1);
      flush(3);
      // chain latency
      a_sel = '1;
      b = {9'd6, 9'd5, 9'd4, 9'd2, 9'd1};
      si_a = 9'h123;
      valid_in = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         si_a = '0;
         if (c == 2) chk("chain_d1_early", {valid_out[1], dout[PW +: PW]}, 0);
         if (c == 3) chk("chain_d1", {valid_out[1], dout[PW +: PW]}, {1'b1, 18'h246});
         if (c == 7) chk("chain_d4_early", {valid_out[4], dout[4*PW +: PW]}, 0);
         if (c == 7) chk("chain_so_a", so_a, 9'h123);
         if (c == 8) chk("chain_d4", {valid_out[4], dout[4*PW +: PW]}, {1'b1, 18'h6D2});
      end
      flush(12);
      // chain with three disabled cycles
      b = {9'd6, 9'd5, 9'd4, 9'd2, 9'd1};
      si_a = 9'h123;
      valid_in = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         si_a = '0;
         if (c == 2) ce = 1'b0;
         if (c == 5) ce = 1'b1;
         if (c == 4) chk("ce_hold_d0", {valid_out[0], dout[PW-1:0]}, {1'b1, 18'h123});
         if (c == 5) chk("ce_hold_d1", {valid_out[1], dout[PW +: PW]}, 0);
         if (c == 6) chk("ce_d1", {valid_out[1], dout[PW +: PW]}, {1'b1, 18'h246});
         if (c == 10) chk("ce_d4_early", valid_out[4], 0);
         if (c == 11) chk("ce_d4", {valid_out[4], dout[4*PW +: PW]}, {1'b1, 18'h6D2});
      end
      flush(12);
      // asynchronous reset in the middle of a chain transfer
      b = {9'd6, 9'd5, 9'd4, 9'd2, 9'd1};
      si_a = 9'h123;
      valid_in = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         si_a = '0;
      end
      chk("pre_reset_active", |valid_out, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_dout", dout, 0);
      chk("async_reset_valid", valid_out, 0);
      chk("async_reset_so_a", so_a, 0);
      @(negedge clk);
      reset = 1'b0;
      valid_in = 1'b0;
      b = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("post_reset_quiet", {so_a, valid_out, dout}, 0);
      end
      // signedness, one operand set per cycle
      a_sel = '0;
      a_local[W-1:0] = 9'h1FF;
      b[W-1:0] = 9'h002;
      a_signed = 1'b1;
      b_signed = 1'b1;
      valid_in = 1'b1;
      @(negedge clk);
      a_signed = 1'b0;
      b_signed = 1'b0;
      @(negedge clk);
      a_signed = 1'b1;
      chk("signed_both", dout[PW-1:0], 18'h3FFFE);
      @(negedge clk);
      chk("unsigned_both", dout[PW-1:0], 18'h003FE);
      a_signed = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
      chk("signed_a_only", dout[PW-1:0], 18'h3FFFE);
      flush(4);
`ifdef MULT_CHAIN_SUM_EN
      a_local = {5{9'd1}};
      b = {9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      chk("sum_valid_early", sum_valid, 0);
      @(negedge clk);
      chk("sum_out", {sum_valid, sum_out}, {1'b1, 21'd15});
      flush(4);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
